// File: rtl/xsoc_mem_pkg.sv
// Shared memory-side definitions for the data cache refill path.
// Holds the refill FSM state encoding, access size codes and the alignment mask.
package xsoc_mem_pkg;

  localparam int unsigned DWORD_W = 64;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  localparam logic [63:0] DWORD_ALIGN_MASK = ~64'h7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_FILL    = 3'd5
  } refill_state_e;

endpackage

// File: rtl/refill_watchdog.sv
// Bus response watchdog: counts wait cycles and raises a sticky error when
// TIMEOUT cycles pass without a response.
module refill_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic rsp_valid,
  output logic expired_c,
  output logic bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // A response on the final wait cycle wins over the timeout.
  assign expired_c = enable & ~rsp_valid & (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      if (clear) begin
        cnt <= '0;
      end else if (enable) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (expired_c) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_refill.sv
// Data cache miss/store handler: fetches a doubleword on load miss, writes
// through on store, then pulses a one-cycle cache update.
module dcache_refill
  import xsoc_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_op,
  input  logic              store_op,
  input  logic              hit,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [63:0]       wdata,
  output logic              stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_write,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [2:0]        bus_req_size,
  output logic [63:0]       bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [63:0]       bus_rsp_data,
  output logic              update,
  output logic [63:0]       update_data,
  output logic              bus_err
);

  refill_state_e     state_q, state_d;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [63:0]       req_wdata;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired_c;
  logic              miss_or_store;

  assign miss_or_store = (load_op & ~hit) | store_op;
  assign wd_enable     = (state_q == ST_RD_WAIT) | (state_q == ST_WR_WAIT);

  refill_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (wd_clear),
    .enable    (wd_enable),
    .rsp_valid (bus_rsp_valid),
    .expired_c (wd_expired_c),
    .bus_err   (bus_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wd_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_op & ~hit) begin
          state_d = ST_RD_REQ;
        end else if (store_op) begin
          state_d = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        if (bus_req_ready) begin
          state_d  = ST_RD_WAIT;
          wd_clear = 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (bus_req_ready) begin
          state_d  = ST_WR_WAIT;
          wd_clear = 1'b1;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (bus_rsp_valid | wd_expired_c) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus request fields are driven only while a request is pending.
  always_comb begin
    stall         = 1'b0;
    bus_req_valid = 1'b0;
    bus_req_write = 1'b0;
    bus_req_addr  = '0;
    bus_req_size  = 3'd0;
    bus_req_wdata = 64'd0;
    update        = 1'b0;
    case (state_q)
      ST_IDLE: stall = miss_or_store;
      ST_RD_REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
        bus_req_addr  = req_addr & ADDR_W'(DWORD_ALIGN_MASK);
        bus_req_size  = SZ_D;
      end
      ST_WR_REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
        bus_req_write = 1'b1;
        bus_req_addr  = req_addr;
        bus_req_size  = req_size;
        bus_req_wdata = req_wdata;
      end
      ST_RD_WAIT, ST_WR_WAIT: stall = 1'b1;
      ST_FILL: update = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Request capture on leaving IDLE; fill data from response or zero on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr    <= '0;
      req_size    <= 3'd0;
      req_wdata   <= 64'd0;
      update_data <= 64'd0;
    end else begin
      if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
        req_addr  <= addr;
        req_size  <= size;
        req_wdata <= wdata;
      end
      if ((state_q == ST_RD_WAIT) && bus_rsp_valid) begin
        update_data <= bus_rsp_data;
      end else if (wd_expired_c) begin
        update_data <= 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_refill.sv
// Self-checking bench for dcache_refill: randomized bus timing checked against
// a transaction-level model of latency, request fields, fill data and errors.
module tb_dcache_refill;

  localparam int unsigned TIMEOUT = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_op, store_op, hit;
  logic [63:0] addr;
  logic [2:0]  size;
  logic [63:0] wdata;
  logic        stall;
  logic        bus_req_valid, bus_req_ready, bus_req_write;
  logic [63:0] bus_req_addr;
  logic [2:0]  bus_req_size;
  logic [63:0] bus_req_wdata;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_data;
  logic        update;
  logic [63:0] update_data;
  logic        bus_err;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] model_ud = 64'd0;
  logic        model_err = 1'b0;

  always #5 clk = ~clk;

  dcache_refill #(
    .TIMEOUT (TIMEOUT),
    .ADDR_W  (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_op       (load_op),
    .store_op      (store_op),
    .hit           (hit),
    .addr          (addr),
    .size          (size),
    .wdata         (wdata),
    .stall         (stall),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_write (bus_req_write),
    .bus_req_addr  (bus_req_addr),
    .bus_req_size  (bus_req_size),
    .bus_req_wdata (bus_req_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_data  (bus_rsp_data),
    .update        (update),
    .update_data   (update_data),
    .bus_err       (bus_err)
  );

  task automatic quiet_inputs();
    load_op       = 1'b0;
    store_op      = 1'b0;
    hit           = 1'b0;
    addr          = 64'd0;
    size          = 3'd0;
    wdata         = 64'd0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = 64'd0;
  endtask

  // One load miss or store; rsp_dly < 0 means the bus never answers.
  task automatic run_txn(input bit is_store, input logic [63:0] a, input logic [2:0] sz,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input int rdy_dly, input int rsp_dly, input string name);
    int          cyc, stall_n, valid_n, bad_fields, upd_cyc, wait_n, exp_stall;
    bit          hs_done, rsp_given, done;
    logic [63:0] got_ud, exp_addr, exp_ud;
    logic [2:0]  exp_size;
    exp_addr  = is_store ? a : {a[63:3], 3'b000};
    exp_size  = is_store ? sz : 3'd3;
    exp_stall = 1 + (rdy_dly + 1) + ((rsp_dly >= 0) ? rsp_dly + 1 : int'(TIMEOUT));
    if (rsp_dly < 0) exp_ud = 64'd0;
    else if (is_store) exp_ud = model_ud;
    else exp_ud = rd;
    cyc = 0; stall_n = 0; valid_n = 0; bad_fields = 0; upd_cyc = -1; wait_n = 0;
    hs_done = 0; rsp_given = 0; done = 0; got_ud = 64'd0;
    while (!done && cyc < 1000) begin
      if (cyc == 0) begin
        load_op = !is_store; store_op = is_store; hit = 1'b0;
        addr = a; size = sz; wdata = wd;
      end else begin
        load_op  = 1'($urandom % 2);
        store_op = !load_op && ($urandom % 2 == 1);
        hit      = 1'($urandom % 2);
        addr     = {$urandom, $urandom};
        size     = 3'($urandom);
        wdata    = {$urandom, $urandom};
      end
      bus_req_ready = (valid_n >= rdy_dly);
      bus_rsp_valid = hs_done && !rsp_given && (rsp_dly >= 0) && (wait_n == rsp_dly);
      bus_rsp_data  = bus_rsp_valid ? rd : {$urandom, $urandom};
      @(negedge clk);
      if (stall) stall_n++;
      if (bus_req_valid) begin
        valid_n++;
        if (bus_req_addr !== exp_addr || bus_req_size !== exp_size ||
            bus_req_write !== is_store || (is_store && bus_req_wdata !== wd))
          bad_fields++;
      end
      if (update) begin
        got_ud = update_data; upd_cyc = cyc; done = 1;
      end
      if (hs_done && !rsp_given) begin
        if (bus_rsp_valid) rsp_given = 1;
        else wait_n++;
      end
      if (bus_req_valid && bus_req_ready) hs_done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    quiet_inputs();
    model_ud = exp_ud;
    if (rsp_dly < 0) model_err = 1'b1;
    checks++; if (!done) begin errors++; $display("FAIL %s no_update: no update within cycle budget", name); end
    checks++; if (stall_n !== exp_stall) begin errors++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_n, exp_stall); end
    checks++; if (valid_n !== rdy_dly + 1) begin errors++; $display("FAIL %s req_valid_cycles: got %0d want %0d", name, valid_n, rdy_dly + 1); end
    checks++; if (bad_fields !== 0) begin errors++; $display("FAIL %s req_fields: %0d bad cycles want 0", name, bad_fields); end
    checks++; if (upd_cyc !== exp_stall) begin errors++; $display("FAIL %s update_cycle: got %0d want %0d", name, upd_cyc, exp_stall); end
    checks++; if (got_ud !== exp_ud) begin errors++; $display("FAIL %s update_data: got %h want %h", name, got_ud, exp_ud); end
    checks++; if (bus_err !== model_err) begin errors++; $display("FAIL %s bus_err: got %b want %b", name, bus_err, model_err); end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL %s update_width: got %b want 0 after fill", name, update); end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({stall, bus_req_valid, bus_req_write, update, bus_err} !== 5'b0 ||
        bus_req_addr !== 64'd0 || bus_req_size !== 3'd0 || bus_req_wdata !== 64'd0 ||
        update_data !== 64'd0) begin
      errors++;
      $display("FAIL %s outputs_zero: stall=%b valid=%b write=%b addr=%h size=%0d wdata=%h update=%b udata=%h err=%b want all 0",
               name, stall, bus_req_valid, bus_req_write, bus_req_addr, bus_req_size,
               bus_req_wdata, update, update_data, bus_err);
    end
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    model_ud = 64'd0; model_err = 1'b0;
  endtask

  task automatic test_load_miss();
    run_txn(1'b0, 64'h0000_0000_8000_0013, 3'd0, 64'd0, 64'h1122334455667788, 0, 2, "load_miss");
  endtask

  task automatic test_hit();
    for (int i = 0; i < 4; i++) begin
      load_op = 1'b1; hit = 1'b1; addr = {$urandom, $urandom}; size = 3'($urandom);
      bus_req_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || bus_req_valid !== 1'b0 || update !== 1'b0) begin
        errors++;
        $display("FAIL load_hit: stall=%b valid=%b update=%b want 0 0 0", stall, bus_req_valid, update);
      end
      @(posedge clk); #1;
    end
    quiet_inputs();
  endtask

  task automatic test_store();
    run_txn(1'b1, 64'h100, 3'd2, 64'h0000_0000_DEAD_BEEF, 64'h5555_AAAA_5555_AAAA, 3, 1, "store");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_txn(1'($urandom % 2), {$urandom, $urandom}, 3'($urandom), {$urandom, $urandom},
              {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 64'h40, 3'd3, 64'd0, 64'hA0A0_A0A0_0000_0040, 0, 0, "b2b_first");
    run_txn(1'b0, 64'h48, 3'd3, 64'd0, 64'hB0B0_B0B0_0000_0048, 0, 0, "b2b_second");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 64'h2000, 3'd3, 64'd0, 64'hCAFE_F00D_1234_5678, 1, int'(TIMEOUT) - 1, "rsp_at_limit");
    run_txn(1'b0, 64'h3008, 3'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, "timeout");
    run_txn(1'b1, 64'h3010, 3'd3, 64'h77, 64'd0, 0, 0, "err_sticky");
  endtask

  task automatic test_reset_midflight();
    load_op = 1'b1; hit = 1'b0; addr = 64'h5000; bus_req_ready = 1'b1;
    @(posedge clk); #1;
    quiet_inputs();
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_wait: stall=%b valid=%b want 1 0", stall, bus_req_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_ud = 64'd0; model_err = 1'b0;
    check_all_zero("midflight_reset");
    bus_rsp_valid = 1'b1; bus_rsp_data = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (update !== 1'b0 || update_data !== 64'd0) begin
        errors++;
        $display("FAIL late_rsp: update=%b data=%h want 0 0", update, update_data);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    quiet_inputs();
    rst = 1'b1;
    test_reset();
    test_load_miss();
    test_hit();
    test_store();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_midflight();
    run_txn(1'b0, 64'h6018, 3'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 2, 3, "after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
